// File: rtl/conv_mem_responder.sv
// Memory-side responder for the CONV layer engine: image ROM, five layer banks,
// ready/busy start handshake, bank stream-out and run statistics.
module conv_mem_responder #(
  parameter int unsigned DW            = 20,
  parameter int unsigned AW            = 12,
  parameter int unsigned L0_DEPTH      = 4096,
  parameter int unsigned L1_DEPTH      = 1024,
  parameter int unsigned L2_DEPTH      = 2048,
  parameter int unsigned READY_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          img_we,
  input  logic [AW-1:0] img_waddr,
  input  logic [DW-1:0] img_wdata,
  input  logic          start,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  input  logic          dump_req,
  input  logic [2:0]    dump_sel,
  output logic          dump_valid,
  output logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          done,
  output logic          err,
  output logic [15:0]   run_cycles,
  output logic [11:0]   wr_count
);

  localparam int unsigned ImgDepth = 2 ** AW;
  localparam int unsigned L0Aw     = $clog2(L0_DEPTH);
  localparam int unsigned L1Aw     = $clog2(L1_DEPTH);
  localparam int unsigned L2Aw     = $clog2(L2_DEPTH);
  localparam int unsigned TmoW     = $clog2(READY_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StReady, StRun, StDone, StDump} state_e;

  state_e            state_q;
  logic              ready_q, done_q, err_q, dump_valid_q;
  logic [AW-1:0]     dump_addr_q;
  logic [DW-1:0]     dump_data_q;
  logic [15:0]       run_cycles_q;
  logic [11:0]       wr_count_q;
  logic [TmoW-1:0]   tmo_q;
  logic [2:0]        dump_sel_q;

  logic [DW-1:0] img_mem [ImgDepth];
  logic [DW-1:0] l0a_mem [L0_DEPTH];
  logic [DW-1:0] l0b_mem [L0_DEPTH];
  logic [DW-1:0] l1a_mem [L1_DEPTH];
  logic [DW-1:0] l1b_mem [L1_DEPTH];
  logic [DW-1:0] l2_mem  [L2_DEPTH];

  // Depth 0 marks an invalid bank select, so range checks also reject bad csel.
  function automatic int unsigned depth_of(input logic [2:0] sel);
    case (sel)
      3'd1, 3'd2: depth_of = L0_DEPTH;
      3'd3, 3'd4: depth_of = L1_DEPTH;
      3'd5:       depth_of = L2_DEPTH;
      default:    depth_of = 0;
    endcase
  endfunction

  logic          wr_ok, wr_bad, rd_ok, img_we_ok, dump_last, err_set;
  logic [2:0]    dsel;
  logic [AW-1:0] draddr;
  logic [DW-1:0] dump_rdata;

  always_comb begin
    wr_ok     = cwr && (32'(caddr_wr) < depth_of(csel));
    wr_bad    = cwr && !wr_ok;
    rd_ok     = crd && (32'(caddr_rd) < depth_of(csel));
    img_we_ok = img_we && (state_q == StIdle) && !reset;
    dump_last = 32'(dump_addr_q) == depth_of(dump_sel_q) - 1;
    err_set   = wr_bad || (img_we && state_q != StIdle)
             || (state_q == StReady && !busy && 32'(tmo_q) == READY_TIMEOUT - 1)
             || (state_q == StDone && !start && dump_req && depth_of(dump_sel) == 0);
  end

  assign idata = img_mem[iaddr];

  always_comb begin
    cdata_rd = '0;
    if (rd_ok) begin
      case (csel)
        3'd1:    cdata_rd = l0a_mem[caddr_rd[L0Aw-1:0]];
        3'd2:    cdata_rd = l0b_mem[caddr_rd[L0Aw-1:0]];
        3'd3:    cdata_rd = l1a_mem[caddr_rd[L1Aw-1:0]];
        3'd4:    cdata_rd = l1b_mem[caddr_rd[L1Aw-1:0]];
        3'd5:    cdata_rd = l2_mem[caddr_rd[L2Aw-1:0]];
        default: cdata_rd = '0;
      endcase
    end
  end

  // Prefetch the word the dump register will hold after the next edge.
  always_comb begin
    dsel       = (state_q == StDump) ? dump_sel_q : dump_sel;
    draddr     = (state_q == StDump) ? dump_addr_q + 1'b1 : '0;
    dump_rdata = '0;
    case (dsel)
      3'd1:    dump_rdata = l0a_mem[draddr[L0Aw-1:0]];
      3'd2:    dump_rdata = l0b_mem[draddr[L0Aw-1:0]];
      3'd3:    dump_rdata = l1a_mem[draddr[L1Aw-1:0]];
      3'd4:    dump_rdata = l1b_mem[draddr[L1Aw-1:0]];
      3'd5:    dump_rdata = l2_mem[draddr[L2Aw-1:0]];
      default: dump_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (img_we_ok) img_mem[img_waddr] <= img_wdata;
    if (wr_ok && !reset) begin
      case (csel)
        3'd1:    l0a_mem[caddr_wr[L0Aw-1:0]] <= cdata_wr;
        3'd2:    l0b_mem[caddr_wr[L0Aw-1:0]] <= cdata_wr;
        3'd3:    l1a_mem[caddr_wr[L1Aw-1:0]] <= cdata_wr;
        3'd4:    l1b_mem[caddr_wr[L1Aw-1:0]] <= cdata_wr;
        3'd5:    l2_mem[caddr_wr[L2Aw-1:0]]  <= cdata_wr;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      run_cycles_q <= '0;
      wr_count_q   <= '0;
      tmo_q        <= '0;
      dump_sel_q   <= '0;
    end else begin
      if (wr_ok && wr_count_q != '1) wr_count_q <= wr_count_q + 1'b1;
      case (state_q)
        StIdle: begin
          if (start) begin
            run_cycles_q <= '0;
            wr_count_q   <= '0;
            err_q        <= 1'b0;
            tmo_q        <= '0;
            ready_q      <= 1'b1;
            state_q      <= StReady;
          end
        end
        StReady: begin
          if (busy) begin
            // The busy edge itself is the first counted run cycle.
            run_cycles_q <= 16'd1;
            ready_q      <= 1'b0;
            state_q      <= StRun;
          end else if (32'(tmo_q) == READY_TIMEOUT - 1) begin
            ready_q <= 1'b0;
            state_q <= StIdle;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StRun: begin
          if (busy) begin
            if (run_cycles_q != '1) run_cycles_q <= run_cycles_q + 1'b1;
          end else begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (start) begin
            run_cycles_q <= '0;
            wr_count_q   <= '0;
            err_q        <= 1'b0;
            tmo_q        <= '0;
            done_q       <= 1'b0;
            ready_q      <= 1'b1;
            state_q      <= StReady;
          end else if (dump_req && depth_of(dump_sel) != 0) begin
            dump_sel_q   <= dump_sel;
            dump_addr_q  <= '0;
            dump_data_q  <= dump_rdata;
            dump_valid_q <= 1'b1;
            state_q      <= StDump;
          end
        end
        StDump: begin
          if (dump_last) begin
            dump_valid_q <= 1'b0;
            dump_data_q  <= '0;
            state_q      <= StDone;
          end else begin
            dump_addr_q <= draddr;
            dump_data_q <= dump_rdata;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (err_set) err_q <= 1'b1;
    end
  end

  assign ready      = ready_q;
  assign done       = done_q;
  assign err        = err_q;
  assign dump_valid = dump_valid_q;
  assign dump_addr  = dump_addr_q;
  assign dump_data  = dump_data_q;
  assign run_cycles = run_cycles_q;
  assign wr_count   = wr_count_q;

endmodule
